// File: rtl/plate_det_pkg.sv
// rtl/plate_det_pkg.sv - shared constants for the plate bounding-box detector
// Contents: RGB565 field slice positions, coordinate width XY_W, FSM state
// encodings (IDLE/ACTIVE/LATCH) and a saturating coordinate increment helper.
package plate_det_pkg;

    localparam int XY_W = 11;
    localparam logic [XY_W-1:0] XY_MAX = '1;

    // RGB565 = {R5, G6, B5}
    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_LATCH  = 2'd2;

    // Counters stick at full scale instead of wrapping.
    function automatic logic [XY_W-1:0] sat_inc(input logic [XY_W-1:0] v);
        return (v == XY_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/plate_row_stat.sv
// rtl/plate_row_stat.sv - per-row blue-pixel count, xmin/xmax and qualify flag
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   pix_blue     current pixel is valid and classified blue
//   pix_x        x coordinate of the current pixel
//   row_end      row boundary (hsync falling edge); stats are cleared
//   row_drop     discard the open row (frame boundary); stats are cleared
//   row_qualify  row_end and the finished row has at least ROW_MIN_CNT blue pixels
//   row_xmin     smallest blue x in the current row
//   row_xmax     largest blue x in the current row
module plate_row_stat
    import plate_det_pkg::*;
#(
    parameter logic [XY_W-1:0] ROW_MIN_CNT = 11'd8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pix_blue,
    input  logic [XY_W-1:0] pix_x,
    input  logic            row_end,
    input  logic            row_drop,
    output logic            row_qualify,
    output logic [XY_W-1:0] row_xmin,
    output logic [XY_W-1:0] row_xmax
);

    logic [XY_W-1:0] cnt;

    // Evaluated on the registered stats, so the row is judged before the clear.
    assign row_qualify = row_end && (cnt >= ROW_MIN_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            row_xmin <= XY_MAX;
            row_xmax <= '0;
        end else if (row_end || row_drop) begin
            cnt      <= '0;
            row_xmin <= XY_MAX;
            row_xmax <= '0;
        end else if (pix_blue) begin
            cnt <= sat_inc(cnt);
            if (pix_x < row_xmin) row_xmin <= pix_x;
            if (pix_x > row_xmax) row_xmax <= pix_x;
        end
    end

endmodule

// File: rtl/plate_box_detect.sv
// rtl/plate_box_detect.sv - plate-blue classification and per-frame bounding box
// Optional feature macro: PLATE_BOX_OVERLAY_EN (draws the previous box outline
// into post_rgb using OVERLAY_RGB).
// Ports:
//   clk, rst_n                  pixel clock, asynchronous active-low reset
//   pre_frame_vsync/hsync/de    input syncs (vsync high = blanking, hsync high = line)
//   pre_rgb                     input RGB565 pixel
//   post_frame_vsync/hsync/de   syncs delayed 2 cycles
//   post_rgb                    pixel delayed 2 cycles (overlay if enabled)
//   box_valid                   last completed frame had a qualifying row
//   box_left/right/top/bottom   bounding box of the qualifying rows
//   frame_done                  1-cycle pulse when box_* update
module plate_box_detect
    import plate_det_pkg::*;
#(
    parameter logic [4:0]      B_MIN       = 5'd16,
    parameter logic [4:0]      R_MAX       = 5'd10,
    parameter logic [5:0]      G_MAX       = 6'd24,
    parameter logic [XY_W-1:0] ROW_MIN_CNT = 11'd8
`ifdef PLATE_BOX_OVERLAY_EN
    ,
    parameter logic [15:0]     OVERLAY_RGB = 16'hF800
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pre_frame_vsync,
    input  logic            pre_frame_hsync,
    input  logic            pre_frame_de,
    input  logic [15:0]     pre_rgb,
    output logic            post_frame_vsync,
    output logic            post_frame_hsync,
    output logic            post_frame_de,
    output logic [15:0]     post_rgb,
    output logic            box_valid,
    output logic [XY_W-1:0] box_left,
    output logic [XY_W-1:0] box_right,
    output logic [XY_W-1:0] box_top,
    output logic [XY_W-1:0] box_bottom,
    output logic            frame_done
);

    logic            vs_d, hs_d;
    logic            vs_rise, hs_fall;
    logic [XY_W-1:0] x_cnt, y_cnt;
    logic [1:0]      state;
    logic            pix_blue;
    logic            row_qualify;
    logic [XY_W-1:0] row_xmin, row_xmax;

    logic            acc_any;
    logic [XY_W-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic            base_any, nxt_any, merge_en;
    logic [XY_W-1:0] base_xmin, base_xmax, base_ymin, base_ymax;
    logic [XY_W-1:0] nxt_xmin, nxt_xmax, nxt_ymin, nxt_ymax;

    logic            s1_vs, s1_hs, s1_de;
    logic [15:0]     s1_rgb;

    assign vs_rise = pre_frame_vsync & ~vs_d;
    assign hs_fall = hs_d & ~pre_frame_hsync;

    // Pixels are ignored until the first full frame starts.
    assign pix_blue = pre_frame_de && (state != ST_IDLE)
                   && (pre_rgb[B_HI:B_LO] >= B_MIN)
                   && (pre_rgb[R_HI:R_LO] <= R_MAX)
                   && (pre_rgb[G_HI:G_LO] <= G_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d  <= 1'b0;
            hs_d  <= 1'b0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            vs_d <= pre_frame_vsync;
            hs_d <= pre_frame_hsync;
            if (hs_fall)           x_cnt <= '0;
            else if (pre_frame_de) x_cnt <= sat_inc(x_cnt);
            if (vs_rise)           y_cnt <= '0;
            else if (hs_fall)      y_cnt <= sat_inc(y_cnt);
        end
    end

    // vsync rise also discards a row that never saw its hsync fall; a row
    // ending in the same cycle is still judged from the pre-clear stats.
    plate_row_stat #(
        .ROW_MIN_CNT (ROW_MIN_CNT)
    ) u_row_stat (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_blue    (pix_blue),
        .pix_x       (x_cnt),
        .row_end     (hs_fall),
        .row_drop    (vs_rise),
        .row_qualify (row_qualify),
        .row_xmin    (row_xmin),
        .row_xmax    (row_xmax)
    );

    // Accumulators start from a clean slate outside ACTIVE; the merge result
    // is what LATCH publishes, so a row ending on vsync rise is included.
    always_comb begin
        if (state == ST_ACTIVE) begin
            base_any  = acc_any;
            base_xmin = acc_xmin;
            base_xmax = acc_xmax;
            base_ymin = acc_ymin;
            base_ymax = acc_ymax;
        end else begin
            base_any  = 1'b0;
            base_xmin = XY_MAX;
            base_xmax = '0;
            base_ymin = '0;
            base_ymax = '0;
        end
        merge_en = row_qualify && (state != ST_IDLE);
        nxt_any  = base_any | merge_en;
        nxt_xmin = (merge_en && (row_xmin < base_xmin)) ? row_xmin : base_xmin;
        nxt_xmax = (merge_en && (row_xmax > base_xmax)) ? row_xmax : base_xmax;
        nxt_ymin = (merge_en && !base_any) ? y_cnt : base_ymin;
        nxt_ymax = merge_en ? y_cnt : base_ymax;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc_any    <= 1'b0;
            acc_xmin   <= XY_MAX;
            acc_xmax   <= '0;
            acc_ymin   <= '0;
            acc_ymax   <= '0;
            box_valid  <= 1'b0;
            box_left   <= '0;
            box_right  <= '0;
            box_top    <= '0;
            box_bottom <= '0;
            frame_done <= 1'b0;
        end else begin
            acc_any    <= nxt_any;
            acc_xmin   <= nxt_xmin;
            acc_xmax   <= nxt_xmax;
            acc_ymin   <= nxt_ymin;
            acc_ymax   <= nxt_ymax;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (vs_rise) state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    // Box registers load on the edge entering LATCH, so
                    // frame_done and the new box appear in the LATCH cycle.
                    if (vs_rise) begin
                        state      <= ST_LATCH;
                        frame_done <= 1'b1;
                        box_valid  <= nxt_any;
                        if (nxt_any) begin
                            box_left   <= nxt_xmin;
                            box_right  <= nxt_xmax;
                            box_top    <= nxt_ymin;
                            box_bottom <= nxt_ymax;
                        end
                    end
                end
                ST_LATCH: state <= ST_ACTIVE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef PLATE_BOX_OVERLAY_EN
    logic s1_hit, on_col, on_row;

    // Perimeter test against the box from the previous frame.
    assign on_col = ((x_cnt == box_left) || (x_cnt == box_right))
                 && (y_cnt >= box_top) && (y_cnt <= box_bottom);
    assign on_row = ((y_cnt == box_top) || (y_cnt == box_bottom))
                 && (x_cnt >= box_left) && (x_cnt <= box_right);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vs            <= 1'b0;
            s1_hs            <= 1'b0;
            s1_de            <= 1'b0;
            s1_rgb           <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_hsync <= 1'b0;
            post_frame_de    <= 1'b0;
            post_rgb         <= '0;
`ifdef PLATE_BOX_OVERLAY_EN
            s1_hit           <= 1'b0;
`endif
        end else begin
            s1_vs            <= pre_frame_vsync;
            s1_hs            <= pre_frame_hsync;
            s1_de            <= pre_frame_de;
            s1_rgb           <= pre_rgb;
            post_frame_vsync <= s1_vs;
            post_frame_hsync <= s1_hs;
            post_frame_de    <= s1_de;
`ifdef PLATE_BOX_OVERLAY_EN
            s1_hit           <= box_valid && pre_frame_de && (on_col || on_row);
            post_rgb         <= s1_hit ? OVERLAY_RGB : s1_rgb;
`else
            post_rgb         <= s1_rgb;
`endif
        end
    end

endmodule

// File: tb/tb_plate_box_detect.sv
// tb/tb_plate_box_detect.sv - self-checking bench for plate_box_detect
module tb_plate_box_detect;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pre_frame_vsync, pre_frame_hsync, pre_frame_de;
    logic [15:0] pre_rgb;
    logic        post_frame_vsync, post_frame_hsync, post_frame_de;
    logic [15:0] post_rgb;
    logic        box_valid;
    logic [10:0] box_left, box_right, box_top, box_bottom;
    logic        frame_done;

    always #5 clk = ~clk;

    plate_box_detect dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pre_frame_vsync  (pre_frame_vsync),
        .pre_frame_hsync  (pre_frame_hsync),
        .pre_frame_de     (pre_frame_de),
        .pre_rgb          (pre_rgb),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_hsync (post_frame_hsync),
        .post_frame_de    (post_frame_de),
        .post_rgb         (post_rgb),
        .box_valid        (box_valid),
        .box_left         (box_left),
        .box_right        (box_right),
        .box_top          (box_top),
        .box_bottom       (box_bottom),
        .frame_done       (frame_done)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;

    logic [15:0] img [0:31][0:63];
    int drv_x = -1;
    int drv_y = -1;

    // Expected box of the frame currently being driven, from the image.
    bit f_valid;
    int f_l, f_r, f_t, f_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_blue(input logic [15:0] p);
        return (p[4:0] >= 5'd16) && (p[15:11] <= 5'd10) && (p[10:5] <= 6'd24);
    endfunction

    task automatic compute_expected();
        f_valid = 1'b0;
        f_l = 0; f_r = 0; f_t = 0; f_b = 0;
        for (int y = 0; y < 32; y++) begin
            int cnt, mn, mx;
            cnt = 0; mn = 2047; mx = 0;
            for (int x = 0; x < 64; x++) begin
                if (is_blue(img[y][x])) begin
                    cnt++;
                    if (x < mn) mn = x;
                    if (x > mx) mx = x;
                end
            end
            if (cnt >= 8) begin
                if (!f_valid) begin
                    f_t = y; f_l = mn; f_r = mx;
                end
                if (mn < f_l) f_l = mn;
                if (mx > f_r) f_r = mx;
                f_b = y;
                f_valid = 1'b1;
            end
        end
    endtask

    // ---------------- model: output expectations ----------------
    logic        h1_vs, h1_hs, h1_de, h2_vs, h2_hs, h2_de;
    logic [15:0] h1_rgb, h2_rgb;
    int          h1_x, h1_y, h2_x, h2_y;
    bit          m_armed, m_done, m_valid;
    int          m_l, m_r, m_t, m_b;
    logic [15:0] m_in_rgb;
    logic        m_vrise;

    function automatic bit on_perim(input int x, input int y);
        return (((x == m_l) || (x == m_r)) && (y >= m_t) && (y <= m_b))
            || (((y == m_t) || (y == m_b)) && (x >= m_l) && (x <= m_r));
    endfunction

    assign m_vrise = pre_frame_vsync & ~h1_vs;

    always_comb begin
        m_in_rgb = pre_rgb;
`ifdef PLATE_BOX_OVERLAY_EN
        if (m_valid && pre_frame_de && (drv_x >= 0) && on_perim(drv_x, drv_y))
            m_in_rgb = 16'hF800;
`endif
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_vs <= 0; h1_hs <= 0; h1_de <= 0; h1_rgb <= 0; h1_x <= -1; h1_y <= -1;
            h2_vs <= 0; h2_hs <= 0; h2_de <= 0; h2_rgb <= 0; h2_x <= -1; h2_y <= -1;
            m_armed <= 0; m_done <= 0; m_valid <= 0;
            m_l <= 0; m_r <= 0; m_t <= 0; m_b <= 0;
        end else begin
            h2_vs <= h1_vs; h2_hs <= h1_hs; h2_de <= h1_de; h2_rgb <= h1_rgb;
            h2_x <= h1_x; h2_y <= h1_y;
            h1_vs <= pre_frame_vsync; h1_hs <= pre_frame_hsync; h1_de <= pre_frame_de;
            h1_rgb <= m_in_rgb; h1_x <= drv_x; h1_y <= drv_y;
            if (m_vrise && m_armed) begin
                m_done  <= 1;
                m_valid <= f_valid;
                if (f_valid) begin
                    m_l <= f_l; m_r <= f_r; m_t <= f_t; m_b <= f_b;
                end
            end else begin
                m_done <= 0;
            end
            if (m_vrise) m_armed <= 1;
        end
    end

    // ---------------- compare process ----------------
    logic [15:0] cap_a, cap_b, cap_c;

    always @(negedge clk) begin
        if (rst_n) begin
            check("post_vsync", post_frame_vsync, h2_vs);
            check("post_hsync", post_frame_hsync, h2_hs);
            check("post_de", post_frame_de, h2_de);
            check("post_rgb", post_rgb, h2_rgb);
            check("frame_done", frame_done, m_done);
            check("box_valid", box_valid, m_valid);
            check("box_left", box_left, m_l);
            check("box_right", box_right, m_r);
            check("box_top", box_top, m_t);
            check("box_bottom", box_bottom, m_b);
            if (frame_done) n_done++;
            if (h2_de && h2_x == 10 && h2_y == 5)  cap_a = post_rgb;
            if (h2_de && h2_x == 29 && h2_y == 14) cap_b = post_rgb;
            if (h2_de && h2_x == 15 && h2_y == 9)  cap_c = post_rgb;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_black();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 64; x++) img[y][x] = 16'h0000;
    endtask

    task automatic set_base();
        set_black();
        for (int y = 5; y <= 14; y++)
            for (int x = 10; x <= 29; x++) img[y][x] = 16'h001F;
    endtask

    task automatic drive_row(input int y, input bit merge_vs, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            pre_frame_hsync = 1; pre_frame_de = 1; pre_rgb = img[y][x];
            drv_x = x; drv_y = y;
            tick();
        end
        if (x1 == 63) begin
            pre_frame_hsync = 0; pre_frame_de = 0; pre_rgb = 16'h0000;
            drv_x = -1; drv_y = -1;
            if (merge_vs) pre_frame_vsync = 1;
            tick();
            if (!merge_vs) begin
                tick(); tick();
            end
        end
    endtask

    // Full 64x32 frame ending with the vsync rise that reports it.
    task automatic run_frame(input bit merge);
        compute_expected();
        pre_frame_vsync = 0;
        tick(); tick();
        for (int y = 0; y < 32; y++) drive_row(y, merge && (y == 31), 0, 63);
        if (!merge) begin
            pre_frame_vsync = 1;
            tick();
        end
        check("frame_done_latency", frame_done, 1'b1);
        tick(); tick(); tick();
        check("frame_done_width", frame_done, 1'b0);
    endtask

    task automatic check_box(input string tag, input int v, input int l, input int r,
                             input int t, input int b);
        check({tag, "_valid"}, box_valid, v);
        check({tag, "_left"}, box_left, l);
        check({tag, "_right"}, box_right, r);
        check({tag, "_top"}, box_top, t);
        check({tag, "_bottom"}, box_bottom, b);
    endtask

    initial begin
        rst_n = 0;
        pre_frame_vsync = 0; pre_frame_hsync = 0; pre_frame_de = 0; pre_rgb = 0;
        cap_a = 0; cap_b = 0; cap_c = 0;
        set_black();
        tick(); tick();
        check("reset_post_rgb", post_rgb, 16'h0000);
        check("reset_box_valid", box_valid, 1'b0);
        check("reset_frame_done", frame_done, 1'b0);
        rst_n = 1;
        tick();

        // Partial frame after reset: never reported, even with blue rows.
        set_base();
        for (int y = 0; y < 10; y++) drive_row(y, 0, 0, 63);
        f_valid = 0;
        pre_frame_vsync = 1;
        tick();
        check("partial_no_done", frame_done, 1'b0);
        tick(); tick(); tick();

        // All-black frame: one done pulse, no box.
        set_black();
        run_frame(0);
        check("black_done_count", n_done, 1);
        check_box("black", 0, 0, 0, 0, 0);

        // Blue block x=10..29, y=5..14.
        set_base();
        run_frame(0);
        check("base_done_count", n_done, 2);
        check_box("base", 1, 10, 29, 5, 14);

        // Short row y=20 (4 pixels) must not qualify.
        set_base();
        for (int x = 50; x <= 53; x++) img[20][x] = 16'h001F;
        run_frame(0);
        check("short_done_count", n_done, 3);
        check_box("short", 1, 10, 29, 5, 14);
`ifdef PLATE_BOX_OVERLAY_EN
        check("overlay_10_5", cap_a, 16'hF800);
        check("overlay_29_14", cap_b, 16'hF800);
        check("overlay_15_9", cap_c, 16'h001F);
`endif

        // Row 31 ends in the same cycle as vsync rises.
        set_base();
        for (int x = 10; x <= 29; x++) img[31][x] = 16'h001F;
        run_frame(1);
        check("merge_done_count", n_done, 4);
        check_box("merge", 1, 10, 29, 5, 31);

        // Random pixels: pass-through and box follow the model.
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 64; x++) img[y][x] = 16'($urandom);
        run_frame(0);
        check("random_done_count", n_done, 5);

        // Reset in the middle of a row.
        set_base();
        pre_frame_vsync = 0;
        tick(); tick();
        for (int y = 0; y < 8; y++) drive_row(y, 0, 0, 63);
        drive_row(8, 0, 0, 31);
        rst_n = 0;
        #1;
        check("rst_box_valid", box_valid, 1'b0);
        check("rst_box_left", box_left, 11'd0);
        check("rst_box_bottom", box_bottom, 11'd0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_post_hsync", post_frame_hsync, 1'b0);
        check("rst_post_de", post_frame_de, 1'b0);
        check("rst_post_rgb", post_rgb, 16'h0000);
        tick();
        rst_n = 1;
        drive_row(8, 0, 32, 63);
        for (int y = 9; y < 32; y++) drive_row(y, 0, 0, 63);
        pre_frame_vsync = 1;
        tick();
        check("rst_partial_no_done", frame_done, 1'b0);
        tick(); tick(); tick();
        run_frame(0);
        check("recover_done_count", n_done, 6);
        check_box("recover", 1, 10, 29, 5, 14);

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
